// File: rtl/gmii_rx_frame_receiver.sv
// GMII receive framer: strips preamble/SFD, checks and strips the FCS, and counts good/bad frames.
// Define RX_MAC_FILTER_EN to add destination-MAC filtering on local_mac or broadcast.
module gmii_rx_frame_receiver #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_dv,
    input  logic             rx_er,
`ifdef RX_MAC_FILTER_EN
    input  logic [47:0]      local_mac,
`endif
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic             out_error,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_bad
);

    // Handshake: no backpressure. out_valid qualifies out_data/out_first/out_last for one
    // cycle; out_error is meaningful only while out_valid && out_last.

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        PREAMBLE  = 3'd2,
        DATA      = 3'd3,
        DROP      = 3'd4
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       first;
        logic       last;
        logic       error;
        logic       inc_ok;
        logic       inc_bad;
        logic [7:0] data;
    } beat_t;

    localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
`ifdef RX_MAC_FILTER_EN
    localparam int XDLY = 4;
`else
    localparam int XDLY = 0;
`endif

    state_t      state;
    state_t      next_state;
    logic        start_frame;
    logic        pre_bad;
    logic        take_byte;
    logic        end_frame;
    logic        oversize;

    logic [31:0] crc;
    logic [10:0] len;
    logic        er_flag;
    logic [7:0]  dly [0:3];
    logic [7:0]  hold;
    logic        frame_bad;
    logic        keep;
    beat_t       beat;
    beat_t       stage [0:XDLY];

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= WAIT_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        pre_bad     = 1'b0;
        take_byte   = 1'b0;
        end_frame   = 1'b0;
        oversize    = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (!rx_dv) next_state = IDLE;
            end
            // The byte present on the rx_dv rise is already a preamble byte, so a frame
            // with zero 0x55 bytes (SFD first) is accepted too.
            IDLE, PREAMBLE: begin
                if (!rx_dv) begin
                    pre_bad    = (state == PREAMBLE);
                    next_state = IDLE;
                end else if (rx_er) begin
                    pre_bad    = 1'b1;
                    next_state = DROP;
                end else if (rx_data == 8'hD5) begin
                    start_frame = 1'b1;
                    next_state  = DATA;
                end else if (rx_data == 8'h55) begin
                    next_state = PREAMBLE;
                end else begin
                    pre_bad    = 1'b1;
                    next_state = DROP;
                end
            end
            DATA: begin
                if (!rx_dv) begin
                    end_frame  = 1'b1;
                    next_state = IDLE;
                end else if (len == MAX_LEN) begin
                    oversize   = 1'b1;
                    next_state = DROP;
                end else begin
                    take_byte = 1'b1;
                end
            end
            DROP: begin
                if (!rx_dv) next_state = IDLE;
            end
            default: next_state = WAIT_IDLE;
        endcase
    end

    // Four-byte delay line holds back the FCS; hold is the next payload byte to emit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc     <= 32'hFFFFFFFF;
            len     <= 11'd0;
            er_flag <= 1'b0;
            hold    <= 8'h00;
            for (int i = 0; i < 4; i++) dly[i] <= 8'h00;
        end else if (start_frame) begin
            crc     <= 32'hFFFFFFFF;
            len     <= 11'd0;
            er_flag <= 1'b0;
        end else if (take_byte) begin
            crc     <= crc32_byte(crc, rx_data);
            if (len != 11'h7FF) len <= len + 11'd1;
            er_flag <= er_flag | rx_er;
            dly[0]  <= rx_data;
            dly[1]  <= dly[0];
            dly[2]  <= dly[1];
            dly[3]  <= dly[2];
            hold    <= dly[3];
        end
    end

`ifdef RX_MAC_FILTER_EN
    logic [39:0] da_buf;
    logic        da_ok;
    logic        da_match;

    // Byte 5 of the DA is checked combinationally as it arrives, which is also when the
    // first payload beat is formed, so that beat can already be suppressed.
    assign da_match = ({da_buf, rx_data} == local_mac) || ({da_buf, rx_data} == 48'hFFFF_FFFF_FFFF);
    assign keep     = (take_byte && len == 11'd5) ? da_match : da_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            da_buf <= 40'h0;
            da_ok  <= 1'b1;
        end else if (start_frame) begin
            da_ok <= 1'b1;
        end else if (take_byte) begin
            if (len < 11'd5) da_buf <= {da_buf[31:0], rx_data};
            if (len == 11'd5) da_ok <= da_match;
        end
    end
`else
    assign keep = 1'b1;
`endif

    always_comb begin
        frame_bad = (crc != CRC_RESIDUE) || er_flag || (len < MIN_LEN);
        beat      = '0;
        if (take_byte && len >= 11'd5) begin
            beat.valid = 1'b1;
            beat.first = (len == 11'd5);
            beat.data  = hold;
        end
        if (end_frame) begin
            if (len >= 11'd5) begin
                beat.valid   = 1'b1;
                beat.first   = (len == 11'd5);
                beat.last    = 1'b1;
                beat.error   = frame_bad;
                beat.data    = hold;
                beat.inc_ok  = !frame_bad;
                beat.inc_bad = frame_bad;
            end else begin
                beat.inc_bad = 1'b1;
            end
        end
        if (oversize) begin
            beat.valid   = 1'b1;
            beat.last    = 1'b1;
            beat.error   = 1'b1;
            beat.data    = hold;
            beat.inc_bad = 1'b1;
        end
        if (!keep) beat = '0;
        if (pre_bad) beat.inc_bad = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= XDLY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= beat;
            for (int i = 1; i <= XDLY; i++) stage[i] <= stage[i-1];
        end
    end

    // Counters step at the end of the cycle that presents out_last.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frames_ok  <= '0;
            frames_bad <= '0;
        end else begin
            if (stage[XDLY].inc_ok && frames_ok != {CNT_W{1'b1}})
                frames_ok <= frames_ok + 1'b1;
            if (stage[XDLY].inc_bad && frames_bad != {CNT_W{1'b1}})
                frames_bad <= frames_bad + 1'b1;
        end
    end

    assign out_valid = stage[XDLY].valid;
    assign out_first = stage[XDLY].first;
    assign out_last  = stage[XDLY].last;
    assign out_error = stage[XDLY].error;
    assign out_data  = stage[XDLY].data;

endmodule

// File: tb/tb_gmii_rx_frame_receiver.sv
// Bench for gmii_rx_frame_receiver: directed frames, expected payload beats queued at issue
// time and checked by an independent output monitor.
`timescale 1ns/1ps
module tb_gmii_rx_frame_receiver;

    localparam int MIN_FRAME = 64;
    localparam int MAX_FRAME = 1518;
    localparam int CNT_W     = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [7:0]       rx_data;
    logic             rx_dv;
    logic             rx_er;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_first;
    logic             out_last;
    logic             out_error;
    logic [CNT_W-1:0] frames_ok;
    logic [CNT_W-1:0] frames_bad;
`ifdef RX_MAC_FILTER_EN
    logic [47:0]      local_mac = 48'h02_00_00_00_00_01;
`endif

    gmii_rx_frame_receiver #(
        .MIN_FRAME(MIN_FRAME),
        .MAX_FRAME(MAX_FRAME),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_data(rx_data),
        .rx_dv(rx_dv),
        .rx_er(rx_er),
`ifdef RX_MAC_FILTER_EN
        .local_mac(local_mac),
`endif
        .out_data(out_data),
        .out_valid(out_valid),
        .out_first(out_first),
        .out_last(out_last),
        .out_error(out_error),
        .frames_ok(frames_ok),
        .frames_bad(frames_bad)
    );

    // ---------------- clock / reset ----------------
    always #4 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_ok   = 0;
    int          exp_bad  = 0;
    logic [10:0] exp_q[$];
    logic [7:0]  frm[$];
    logic [10:0] e_beat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // Beat encoding: {first, last, error, data}
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data 0x%0h first %0b last %0b error %0b, expected no output at %0t",
                             out_data, out_first, out_last, out_error, $time);
                end else begin
                    e_beat = exp_q.pop_front();
                    check("out_beat", {21'h0, out_first, out_last, out_error, out_data}, {21'h0, e_beat});
                end
            end else begin
                check("idle_flags", {29'h0, out_first, out_last, out_error}, 32'h0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(posedge clock);
        #1;
        rx_data = d;
        rx_dv   = dv;
        rx_er   = er;
    endtask

    function automatic logic [31:0] eth_fcs();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (frm[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    // Payload starts with a broadcast DA, followed by a seeded byte pattern, then the FCS.
    function automatic void build_frame(input int plen, input int seed);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < plen; i++) begin
            if (i < 6) frm.push_back(8'hFF);
            else       frm.push_back(8'((i * 7 + seed * 13) & 255));
        end
        fcs = eth_fcs();
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    endfunction

    task automatic send_frame(input int npre, input int er_idx, input bit flip_fcs, input int gap);
        int   flen;
        int   plen;
        logic bad;
        logic f;
        logic l;
        flen = frm.size();
        if (flip_fcs) frm[flen-1] = ~frm[flen-1];
        if (flen <= 4) begin
            exp_bad++;
        end else begin
            if (flen > MAX_FRAME) begin
                plen = MAX_FRAME - 4;
                bad  = 1'b1;
            end else begin
                plen = flen - 4;
                bad  = flip_fcs || (er_idx >= 0 && er_idx < flen) || (flen < MIN_FRAME);
            end
            for (int k = 0; k < plen; k++) begin
                f = (k == 0);
                l = (k == plen - 1);
                exp_q.push_back({f, l, l & bad, frm[k]});
            end
            if (bad) exp_bad++;
            else     exp_ok++;
        end
        for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < flen; i++) drive(frm[i], 1'b1, (i == er_idx));
        for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_pre_err();
        for (int i = 0; i < 3; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive(8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0);
        exp_bad++;
    endtask

    task automatic check_counters(input string name);
        repeat (10) @(posedge clock);
        @(negedge clock);
        check({name, "_frames_ok"}, 32'(frames_ok), 32'(exp_ok));
        check({name, "_frames_bad"}, 32'(frames_bad), 32'(exp_bad));
        check({name, "_drained"}, exp_q.size(), 32'h0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_out_valid"}, 32'(out_valid), 32'h0);
        check({name, "_out_flags"}, {29'h0, out_first, out_last, out_error}, 32'h0);
        check({name, "_out_data"}, 32'(out_data), 32'h0);
        check({name, "_frames_ok"}, 32'(frames_ok), 32'h0);
        check({name, "_frames_bad"}, 32'(frames_bad), 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset   = 1'b1;
        rx_data = 8'h00;
        rx_dv   = 1'b0;
        rx_er   = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset");
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) drive(8'h00, 1'b0, 1'b0);

        build_frame(60, 1);   send_frame(7, -1, 1'b0, 12); check_counters("good64");
        build_frame(60, 1);   send_frame(7, -1, 1'b1, 12); check_counters("bad_fcs");
        build_frame(60, 2);   send_frame(7, 20, 1'b0, 12); check_counters("rx_er");
        send_pre_err();                                    check_counters("pre_err");
        build_frame(16, 3);   send_frame(7, -1, 1'b0, 12); check_counters("runt20");
        build_frame(1, 4);    send_frame(7, -1, 1'b0, 12); check_counters("len5");
        build_frame(0, 5);    send_frame(7, -1, 1'b0, 12); check_counters("len4");
        build_frame(1596, 6); send_frame(7, -1, 1'b0, 12); check_counters("oversize");
        build_frame(60, 7);   send_frame(7, -1, 1'b0, 12); check_counters("after_oversize");

        // Back-to-back frames with a single idle cycle between them
        build_frame(60, 8);   send_frame(7, -1, 1'b0, 1);
        build_frame(100, 9);  send_frame(3, -1, 1'b0, 12); check_counters("back_to_back");

        // Reset in the middle of a frame while rx_dv stays high
        build_frame(60, 10);
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(frm[i], 1'b1, 1'b0);
        @(posedge clock);
        #1;
        reset   = 1'b1;
        rx_data = frm[3];
        for (int i = 4; i < 6; i++) drive(frm[i], 1'b1, 1'b0);
        @(negedge clock);
        check_outputs_zero("mid_reset");
        exp_ok  = 0;
        exp_bad = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 6; i < 40; i++) drive(frm[i], 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0);
        check_counters("post_reset_idle");
        build_frame(60, 11);  send_frame(7, -1, 1'b0, 12); check_counters("post_reset_frame");

        check("final_queue_empty", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
